// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm_if
// Desc     : Instruction-field / status inputs and datapath control outputs
//            of the multi-cycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_ctrl_fsm_if;
  logic [5:0] OP;
  logic [5:0] Fun;
  logic       zero;
  logic       MIO_ready;

  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       Branch;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       CPU_MIO;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALU_Control;
  logic [4:0] state_out;

  modport master (
    input  OP, Fun, zero, MIO_ready,
    output IRWrite, PCWrite, PCWriteCond, Branch, IorD, MemRead, MemWrite,
           RegWrite, ALUSrcA, CPU_MIO, MemtoReg, RegDst, ALUSrcB, PCSource,
           ALU_Control, state_out
  );

  modport slave (
    output OP, Fun, zero, MIO_ready,
    input  IRWrite, PCWrite, PCWriteCond, Branch, IorD, MemRead, MemWrite,
           RegWrite, ALUSrcA, CPU_MIO, MemtoReg, RegDst, ALUSrcB, PCSource,
           ALU_Control, state_out
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Desc     : Multi-cycle MIPS control FSM. Define MC_CTRL_JAL_EN to add jal.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [4:0] {
    S_IF  = 5'd0,
    S_ID  = 5'd1,
    S_MA  = 5'd2,
    S_MRD = 5'd3,
    S_LWB = 5'd4,
    S_MWR = 5'd5,
    S_REX = 5'd6,
    S_RWB = 5'd7,
    S_BEQ = 5'd8,
    S_J   = 5'd9,
    S_IEX = 5'd10,
`ifdef MC_CTRL_JAL_EN
    S_IWB = 5'd11,
    S_JAL = 5'd12
`else
    S_IWB = 5'd11
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_irwrite, w_pcwrite, w_pcwritecond, w_branch, w_iord;
  logic       w_memread, w_memwrite, w_regwrite, w_alusrca, w_cpu_mio;
  logic [1:0] w_memtoreg, w_regdst, w_alusrcb, w_pcsource;
  logic [2:0] w_alu_control;

  // The branch condition itself is resolved in the datapath from zero/Branch.
  logic       w_unused;
  assign w_unused = bus.zero;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = S_IF;
    w_irwrite     = 1'b0;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_branch      = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_cpu_mio     = 1'b0;
    w_memtoreg    = 2'b00;
    w_regdst      = 2'b00;
    w_alusrcb     = 2'b00;
    w_pcsource    = 2'b00;
    w_alu_control = 3'b000;
    case (r_state)
      S_IF: begin
        w_memread     = 1'b1;
        w_cpu_mio     = 1'b1;
        w_alusrcb     = 2'b01;
        w_alu_control = 3'b010;
        w_irwrite     = bus.MIO_ready;
        w_pcwrite     = bus.MIO_ready;
        w_next        = bus.MIO_ready ? S_ID : S_IF;
      end
      S_ID: begin
        w_alusrcb     = 2'b11;
        w_alu_control = 3'b010;
        case (bus.OP)
          6'h00:                      w_next = S_REX;
          6'h23, 6'h2B:               w_next = S_MA;
          6'h04, 6'h05:               w_next = S_BEQ;
          6'h02:                      w_next = S_J;
          6'h08, 6'h0C, 6'h0D, 6'h0A: w_next = S_IEX;
`ifdef MC_CTRL_JAL_EN
          6'h03:                      w_next = S_JAL;
`endif
          default:                    w_next = S_IF;
        endcase
      end
      S_MA: begin
        w_alusrca     = 1'b1;
        w_alusrcb     = 2'b10;
        w_alu_control = 3'b010;
        w_next        = (bus.OP == 6'h23) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_cpu_mio = 1'b1;
        w_next    = bus.MIO_ready ? S_LWB : S_MRD;
      end
      S_LWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 2'b01;
      end
      S_MWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_cpu_mio  = 1'b1;
        w_next     = bus.MIO_ready ? S_IF : S_MWR;
      end
      S_REX: begin
        w_alusrca = 1'b1;
        w_next    = S_RWB;
        case (bus.Fun)
          6'h22:   w_alu_control = 3'b110;
          6'h24:   w_alu_control = 3'b000;
          6'h25:   w_alu_control = 3'b001;
          6'h26:   w_alu_control = 3'b011;
          6'h27:   w_alu_control = 3'b100;
          6'h02:   w_alu_control = 3'b101;
          6'h2A:   w_alu_control = 3'b111;
          default: w_alu_control = 3'b010;
        endcase
      end
      S_RWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 2'b01;
      end
      S_BEQ: begin
        w_alusrca     = 1'b1;
        w_alu_control = 3'b110;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
        w_branch      = (bus.OP == 6'h04);
      end
      S_J: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
      end
      S_IEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_IWB;
        case (bus.OP)
          6'h0C:   w_alu_control = 3'b000;
          6'h0D:   w_alu_control = 3'b001;
          6'h0A:   w_alu_control = 3'b111;
          default: w_alu_control = 3'b010;
        endcase
      end
      S_IWB: begin
        w_regwrite = 1'b1;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
        w_regwrite = 1'b1;
        w_regdst   = 2'b10;
        w_memtoreg = 2'b10;
      end
`endif
      default: w_next = S_IF;
    endcase
  end

  // Reset forces every strobe low so an in-flight memory access is dropped.
  assign bus.IRWrite     = w_irwrite     & ~rst;
  assign bus.PCWrite     = w_pcwrite     & ~rst;
  assign bus.PCWriteCond = w_pcwritecond & ~rst;
  assign bus.Branch      = w_branch      & ~rst;
  assign bus.IorD        = w_iord        & ~rst;
  assign bus.MemRead     = w_memread     & ~rst;
  assign bus.MemWrite    = w_memwrite    & ~rst;
  assign bus.RegWrite    = w_regwrite    & ~rst;
  assign bus.ALUSrcA     = w_alusrca     & ~rst;
  assign bus.CPU_MIO     = w_cpu_mio     & ~rst;
  assign bus.MemtoReg    = rst ? 2'b00  : w_memtoreg;
  assign bus.RegDst      = rst ? 2'b00  : w_regdst;
  assign bus.ALUSrcB     = rst ? 2'b00  : w_alusrcb;
  assign bus.PCSource    = rst ? 2'b00  : w_pcsource;
  assign bus.ALU_Control = rst ? 3'b000 : w_alu_control;
  assign bus.state_out   = r_state;

endmodule
`default_nettype wire
